lw_sw_controller: RTL and testbench
===================================

// Module: lw_sw_controller
// PURPOSE
//  Multi-cycle sequencer for the LW/SW datapath (register file + ALU + data memory).
//  Accepts one memory instruction per start/done handshake and decodes it into rs/rt/offset fields.
//  Steps the datapath through DECODE->ADDR->MEM->WB, driving ALU_Sel/MemRead/MemWrite/RegWrite.
//  Returns loaded data and a one-cycle done pulse to the issuing stage.
// PARAMETERS
//  REG_W   5   register index width (rs/rt)
//  OFF_W   8   offset field width
//  DATA_W  16  memory/load data width
//  MEM_LAT 1   cycles spent in MEM (memory access latency), legal 1..15
// PORTS
//  clk        in   1                     rising-edge clock
//  rst_n      in   1                     asynchronous, active-low reset
//  start      in   1                     request; sampled only in IDLE
//  instr      in   2+2*REG_W+OFF_W (20)  {op[1:0], rs, rt, offset}; op 00=LW 01=SW 10=NOP 11=illegal
//  mem_data   in   DATA_W                datapath Mem_Out
//  busy       out  1                     high in every state except IDLE
//  done       out  1                     one-cycle pulse in DONE
//  err        out  1                     one-cycle pulse in DONE when op==11
//  rs         out  REG_W                 base register index to datapath
//  rt         out  REG_W                 target/source register index to datapath
//  offset     out  OFF_W                 immediate offset to datapath
//  ALU_Sel    out  4                     ALU op; 4'b0000 (ADD) in ADDR/MEM, else 4'b0000 held
//  MemRead    out  1                     memory read enable (LW, MEM state only)
//  MemWrite   out  1                     memory write enable (SW, MEM state only)
//  RegWrite   out  1                     register write enable (LW, WB state only)
//  load_data  out  DATA_W                mem_data captured in WB; holds until next LW
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; busy,done,err,MemRead,MemWrite,RegWrite=0; rs,rt,offset,load_data=0; ALU_Sel=0; wait counter=0.
//  Reset mid-operation: abort immediately; no partial RegWrite/MemWrite after rst_n falls; no done pulse.
//  All outputs registered (Moore); values below are those present during the named state.
//  IDLE:   start=1 -> latch instr fields into op/rs/rt/offset regs, go DECODE; start=0 -> stay.
//  DECODE: op 00/01 -> ADDR; op 10 -> DONE; op 11 -> DONE with err flagged.
//  ADDR:   ALU_Sel=ADD, rs/offset stable; ALU computes rs+offset; -> MEM, counter=MEM_LAT-1.
//  MEM:    MemRead=1 (LW) or MemWrite=1 (SW) every cycle in MEM; counter decrements;
//          exit when counter==0: LW -> WB, SW -> DONE. Exactly MEM_LAT cycles in MEM.
//  WB:     RegWrite=1 for exactly one cycle; load_data<=mem_data at the WB->DONE edge; -> DONE.
//  DONE:   done=1 (one cycle), err=1 iff op==11; -> IDLE.
//  start while busy: ignored, not queued; instr may change freely after acceptance.
//  start held high continuously: new instr accepted on the first IDLE cycle after DONE.
//  MemRead and MemWrite never high together; RegWrite never high for SW/NOP/illegal.
//  rs/rt/offset hold last accepted values from DECODE through the following IDLE.
//  Latency (start-accept edge to done high), MEM_LAT=L: LW 4+L, SW 3+L, NOP/illegal 2 cycles.
//  Counter width 4 bits; MEM_LAT=0 or >15 unsupported (elaboration check required).
// TESTING
//  1 Reset: rst_n=0 with start=1 -> all outputs 0, busy=0; release -> IDLE, no spurious done.
//  2 LW: instr={00,5'h10,5'h11,8'h04}, Mem_Out=16'h00AB, MEM_LAT=1 -> MemRead 1 cycle, RegWrite 1 cycle,
//    load_data=16'h00AB, done 5 cycles after accept, MemWrite stays 0.
//  3 SW: instr={01,5'h10,5'h12,8'h08}, MEM_LAT=3 -> MemWrite high exactly 3 cycles, RegWrite never, done 6 cycles after accept.
//  4 NOP/illegal: op=10 -> done 2 cycles after accept, err=0; op=11 -> done 2 cycles after accept with err=1; no enables.
//  5 Back-to-back: start held high, LW then SW -> second accepted the cycle after DONE; start pulses mid-op ignored.
//  6 Reset mid-MEM of SW (MEM_LAT=3, assert rst_n=0 in 2nd MEM cycle) -> MemWrite drops at once, no done, IDLE after release.

Source files
------------

// File: rtl/lw_sw_controller.sv
// Multi-cycle LW/SW sequencer: IDLE->DECODE->ADDR->MEM(xMEM_LAT)->WB->DONE with Moore registered outputs.
// Latency from the start-sampling cycle to done: LW 4+MEM_LAT, SW 3+MEM_LAT, NOP/illegal 2; start is ignored while busy.
module lw_sw_controller #(
  parameter int REG_W   = 5,
  parameter int OFF_W   = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [2+2*REG_W+OFF_W-1:0]  instr,
  input  logic [DATA_W-1:0]           mem_data,
  output logic                        busy,
  output logic                        done,
  output logic                        err,
  output logic [REG_W-1:0]            rs,
  output logic [REG_W-1:0]            rt,
  output logic [OFF_W-1:0]            offset,
  output logic [3:0]                  ALU_Sel,
  output logic                        MemRead,
  output logic                        MemWrite,
  output logic                        RegWrite,
  output logic [DATA_W-1:0]           load_data
);

  localparam int          IW      = 2 + 2*REG_W + OFF_W;
  localparam logic [3:0]  ALU_ADD = 4'b0000;
  localparam logic [3:0]  LAT_M1  = 4'(MEM_LAT - 1);
  localparam logic [1:0]  OP_LW   = 2'b00;
  localparam logic [1:0]  OP_SW   = 2'b01;
  localparam logic [1:0]  OP_ILL  = 2'b11;

  generate
    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_mem_lat
      $error("lw_sw_controller: MEM_LAT must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_ADDR, S_MEM, S_WB, S_DONE
  } state_t;

  state_t     state;
  logic [1:0] op;
  logic [3:0] cnt;

  // Outputs are assigned on the edge entering a state so they are valid for that whole state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op        <= 2'b00;
      cnt       <= 4'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      rs        <= '0;
      rt        <= '0;
      offset    <= '0;
      ALU_Sel   <= 4'b0000;
      MemRead   <= 1'b0;
      MemWrite  <= 1'b0;
      RegWrite  <= 1'b0;
      load_data <= '0;
    end else begin
      done     <= 1'b0;
      err      <= 1'b0;
      MemRead  <= 1'b0;
      MemWrite <= 1'b0;
      RegWrite <= 1'b0;
      ALU_Sel  <= ALU_ADD;
      case (state)
        S_IDLE: begin
          if (start) begin
            op     <= instr[IW-1 -: 2];
            rs     <= instr[IW-3 -: REG_W];
            rt     <= instr[OFF_W+REG_W-1 -: REG_W];
            offset <= instr[OFF_W-1:0];
            busy   <= 1'b1;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (op == OP_LW || op == OP_SW) begin
            state <= S_ADDR;
          end else begin
            done  <= 1'b1;
            err   <= (op == OP_ILL);
            state <= S_DONE;
          end
        end
        S_ADDR: begin
          cnt      <= LAT_M1;
          MemRead  <= (op == OP_LW);
          MemWrite <= (op == OP_SW);
          state    <= S_MEM;
        end
        S_MEM: begin
          if (cnt == 4'd0) begin
            if (op == OP_LW) begin
              RegWrite <= 1'b1;
              state    <= S_WB;
            end else begin
              done  <= 1'b1;
              state <= S_DONE;
            end
          end else begin
            cnt      <= cnt - 4'd1;
            MemRead  <= (op == OP_LW);
            MemWrite <= (op == OP_SW);
          end
        end
        S_WB: begin
          load_data <= mem_data;
          done      <= 1'b1;
          state     <= S_DONE;
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lw_sw_controller.sv
// Bench for lw_sw_controller: two instances (MEM_LAT=1 and 3) checked each cycle against a timeline model.
module tb_lw_sw_controller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b1;
  logic [19:0] instr = 20'd0;
  logic [15:0] mem_data = 16'h00AB;

  logic        busy_o [2];
  logic        done_o [2];
  logic        err_o  [2];
  logic [4:0]  rs_o   [2];
  logic [4:0]  rt_o   [2];
  logic [7:0]  off_o  [2];
  logic [3:0]  alu_o  [2];
  logic        mr_o   [2];
  logic        mw_o   [2];
  logic        rw_o   [2];
  logic [15:0] ld_o   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lw_sw_controller #(.REG_W(5), .OFF_W(8), .DATA_W(16), .MEM_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_data(mem_data),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .rs(rs_o[0]), .rt(rt_o[0]),
    .offset(off_o[0]), .ALU_Sel(alu_o[0]), .MemRead(mr_o[0]), .MemWrite(mw_o[0]),
    .RegWrite(rw_o[0]), .load_data(ld_o[0]));

  lw_sw_controller #(.REG_W(5), .OFF_W(8), .DATA_W(16), .MEM_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start), .instr(instr), .mem_data(mem_data),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .rs(rs_o[1]), .rt(rt_o[1]),
    .offset(off_o[1]), .ALU_Sel(alu_o[1]), .MemRead(mr_o[1]), .MemWrite(mw_o[1]),
    .RegWrite(rw_o[1]), .load_data(ld_o[1]));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // Cycles from the start-sampling cycle to the done cycle.
  function automatic int dur(input logic [1:0] op, input int l);
    if (op == 2'b00) return 4 + l;
    if (op == 2'b01) return 3 + l;
    return 2;
  endfunction

  // Model: t counts cycles since the start-sampling cycle (t=0); active while t in 1..dur.
  int          cyc = 0;
  bit          m_act [2] = '{0, 0};
  int          m_t   [2] = '{0, 0};
  logic [1:0]  m_op  [2] = '{2'b0, 2'b0};
  logic [4:0]  m_rs  [2] = '{5'd0, 5'd0};
  logic [4:0]  m_rt  [2] = '{5'd0, 5'd0};
  logic [7:0]  m_off [2] = '{8'd0, 8'd0};
  logic [15:0] m_ld  [2] = '{16'd0, 16'd0};
  int          acc_cyc [2] = '{0, 0};

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_act[i] = 0; m_t[i] = 0; m_op[i] = 2'b0;
        m_rs[i] = 5'd0; m_rt[i] = 5'd0; m_off[i] = 8'd0; m_ld[i] = 16'd0;
      end else if (m_act[i]) begin
        if (m_t[i] == dur(m_op[i], lat_of(i))) begin
          m_act[i] = 0;
        end else begin
          if (m_op[i] == 2'b00 && m_t[i] == dur(m_op[i], lat_of(i)) - 1) m_ld[i] = mem_data;
          m_t[i] = m_t[i] + 1;
        end
      end else if (start) begin
        m_act[i] = 1; m_t[i] = 1; acc_cyc[i] = cyc;
        m_op[i] = instr[19:18]; m_rs[i] = instr[17:13]; m_rt[i] = instr[12:8]; m_off[i] = instr[7:0];
      end
    end
    cyc = cyc + 1;
  end

  int n_mr [2] = '{0, 0};
  int n_mw [2] = '{0, 0};
  int n_rw [2] = '{0, 0};
  int n_done [2] = '{0, 0};
  int n_err [2] = '{0, 0};
  int done_cyc [2] = '{0, 0};

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic        a;
      int          t, l;
      logic [9:0]  e_ctrl;
      logic [17:0] e_fld;
      logic [15:0] e_ld;
      a = m_act[i] && rst_n;
      t = m_t[i];
      l = lat_of(i);
      e_ctrl = {a,
                a && t == dur(m_op[i], l),
                a && t == dur(m_op[i], l) && m_op[i] == 2'b11,
                a && m_op[i] == 2'b00 && t >= 3 && t <= 2 + l,
                a && m_op[i] == 2'b01 && t >= 3 && t <= 2 + l,
                a && m_op[i] == 2'b00 && t == 3 + l,
                4'b0000};
      e_fld = rst_n ? {m_rs[i], m_rt[i], m_off[i]} : 18'd0;
      e_ld  = rst_n ? m_ld[i] : 16'd0;
      chk($sformatf("ctrl_dut%0d", i),
          {busy_o[i], done_o[i], err_o[i], mr_o[i], mw_o[i], rw_o[i], alu_o[i]}, e_ctrl);
      chk($sformatf("fields_dut%0d", i), {rs_o[i], rt_o[i], off_o[i]}, e_fld);
      chk($sformatf("load_data_dut%0d", i), ld_o[i], e_ld);
      if (rst_n) begin
        if (mr_o[i]) n_mr[i]++;
        if (mw_o[i]) n_mw[i]++;
        if (rw_o[i]) n_rw[i]++;
        if (err_o[i]) n_err[i]++;
        if (done_o[i]) begin n_done[i]++; done_cyc[i] = cyc; end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic issue(input logic [19:0] ins);
    start = 1'b1;
    instr = ins;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((busy_o[0] || busy_o[1]) && k < 60) begin tick(); k++; end
    chk("idle_timeout", k < 60, 1'b1);
    tick();
  endtask

  int b_mr [2], b_mw [2], b_rw [2], b_done [2], b_err [2];

  task automatic snap();
    for (int i = 0; i < 2; i++) begin
      b_mr[i] = n_mr[i]; b_mw[i] = n_mw[i]; b_rw[i] = n_rw[i];
      b_done[i] = n_done[i]; b_err[i] = n_err[i];
    end
  endtask

  localparam logic [19:0] LW_A  = {2'b00, 5'h10, 5'h11, 8'h04};
  localparam logic [19:0] SW_A  = {2'b01, 5'h10, 5'h12, 8'h08};
  localparam logic [19:0] NOP_A = {2'b10, 5'h01, 5'h02, 8'h03};
  localparam logic [19:0] ILL_A = {2'b11, 5'h04, 5'h05, 8'h06};
  localparam logic [19:0] LW_B  = {2'b00, 5'h02, 5'h03, 8'h20};
  localparam logic [19:0] SW_B  = {2'b01, 5'h07, 5'h08, 8'h10};

  initial begin
    int k;
    // Reset held with start asserted.
    instr = LW_A;
    #1 rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", {busy_o[0], busy_o[1]}, 2'b00);
    chk("rst_ld", ld_o[0], 16'h0000);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (4) tick();
    chk("rst_no_done", n_done[0] + n_done[1], 0);

    // LW
    snap();
    mem_data = 16'h00AB;
    issue(LW_A);
    chk("lw_fields", {rs_o[0], rt_o[0], off_o[0]}, {5'h10, 5'h11, 8'h04});
    wait_idle();
    chk("lw_memread_l1", n_mr[0] - b_mr[0], 1);
    chk("lw_memread_l3", n_mr[1] - b_mr[1], 3);
    chk("lw_regwrite", n_rw[0] - b_rw[0], 1);
    chk("lw_memwrite", n_mw[0] - b_mw[0], 0);
    chk("lw_load_data", ld_o[0], 16'h00AB);
    chk("lw_latency_l1", done_cyc[0] - acc_cyc[0], 5);
    chk("lw_latency_l3", done_cyc[1] - acc_cyc[1], 7);

    // SW
    snap();
    mem_data = 16'h5555;
    issue(SW_A);
    wait_idle();
    chk("sw_memwrite_l3", n_mw[1] - b_mw[1], 3);
    chk("sw_regwrite", n_rw[1] - b_rw[1] + n_rw[0] - b_rw[0], 0);
    chk("sw_latency_l3", done_cyc[1] - acc_cyc[1], 6);
    chk("sw_latency_l1", done_cyc[0] - acc_cyc[0], 4);
    chk("sw_ld_hold", ld_o[1], 16'h00AB);

    // NOP and illegal
    snap();
    issue(NOP_A);
    wait_idle();
    chk("nop_latency", done_cyc[0] - acc_cyc[0], 2);
    chk("nop_err", n_err[0] - b_err[0], 0);
    snap();
    issue(ILL_A);
    wait_idle();
    chk("ill_latency", done_cyc[1] - acc_cyc[1], 2);
    chk("ill_err", n_err[0] - b_err[0], 1);
    chk("ill_enables", (n_mr[0] - b_mr[0]) + (n_mw[0] - b_mw[0]) + (n_rw[0] - b_rw[0]), 0);

    // Back-to-back with start held high
    snap();
    mem_data = 16'h1234;
    start = 1'b1;
    instr = LW_B;
    tick();
    k = 0;
    while (!done_o[0] && k < 20) begin tick(); k++; end
    chk("b2b_done_timeout", k < 20, 1'b1);
    instr = SW_B;
    tick();
    chk("b2b_idle_gap", busy_o[0], 1'b0);
    tick();
    chk("b2b_second_accept", {busy_o[0], rs_o[0], rt_o[0]}, {1'b1, 5'h07, 5'h08});
    chk("b2b_accept_after_done", acc_cyc[0] - done_cyc[0], 1);
    start = 1'b0;
    wait_idle();
    chk("b2b_done_count", n_done[0] - b_done[0], 2);
    chk("b2b_load_data", ld_o[0], 16'h1234);

    // Reset during the second MEM cycle of an SW on the MEM_LAT=3 instance
    snap();
    issue(SW_A);
    repeat (3) tick();
    chk("mid_mw_before", mw_o[1], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_mw_after", {mw_o[1], busy_o[1], busy_o[0], done_o[0]}, 4'b0000);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("mid_no_done", (n_done[0] - b_done[0]) + (n_done[1] - b_done[1]), 0);
    chk("mid_idle", {busy_o[0], busy_o[1]}, 2'b00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

endmodule
